ifid_skid_stage: RTL

- Parametrised successor to the fetch/decode pipeline register: a two-entry skid-buffered pipeline stage carrying instruction and PC from fetch to decode.
- Uses a valid/ready handshake in both directions instead of a bare write-enable.
- Fully registered `in_ready`, so backpressure never forms a combinational path from decode to fetch.
- Supports flush with bubble (NOP) insertion, and parametrisable instruction/address widths.

---
 rtl/ifid_skid_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ifid_skid_stage.sv
// Fetch-to-decode pipeline stage: two-entry skid buffer (head + skid) with a
// valid/ready handshake on both sides, registered in_ready and flush to bubble.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | head and skid invalid
// ST_ONE   | head valid, skid invalid
// ST_FULL  | head and skid valid, in_ready held low
module ifid_skid_stage #(
    parameter int unsigned       INST_W      = 32,
    parameter int unsigned       PC_W        = 64,
    parameter logic [INST_W-1:0] NOP_INST    = '0,
    parameter bit                ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [INST_W-1:0] h_inst_q, h_inst_d;
    logic [PC_W-1:0]   h_pc_q, h_pc_d;
    logic [INST_W-1:0] s_inst_q, s_inst_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occupancy_q, occupancy_d;

    logic h_valid;
    logic accept;
    logic pop;

    assign h_valid = (state_q != ST_EMPTY);
    assign accept  = in_valid & in_ready_q;
    assign pop     = h_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            h_inst_q    <= NOP_INST;
            h_pc_q      <= '0;
            s_inst_q    <= '0;
            s_pc_q      <= '0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            h_inst_q    <= h_inst_d;
            h_pc_q      <= h_pc_d;
            s_inst_q    <= s_inst_d;
            s_pc_q      <= s_pc_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Flush only invalidates; data registers keep their contents so the
    // non-bubble variant can keep showing the last head.
    always_comb begin
        state_d  = state_q;
        h_inst_d = h_inst_q;
        h_pc_d   = h_pc_q;
        s_inst_d = s_inst_q;
        s_pc_d   = s_pc_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        h_inst_d = in_inst;
                        h_pc_d   = in_pc;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        h_inst_d = in_inst;
                        h_pc_d   = in_pc;
                    end else if (accept) begin
                        s_inst_d = in_inst;
                        s_pc_d   = in_pc;
                        state_d  = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        h_inst_d = s_inst_q;
                        h_pc_d   = s_pc_q;
                        state_d  = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready_d = (state_d != ST_FULL);
        case (state_d)
            ST_ONE:  occupancy_d = 2'd1;
            ST_FULL: occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
        out_valid = h_valid;
        if (ZERO_BUBBLE && !h_valid) begin
            out_inst = NOP_INST;
            out_pc   = '0;
        end else begin
            out_inst = h_inst_q;
            out_pc   = h_pc_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = occupancy_q;

endmodule
